decode_execute_stage: RTL and testbench
=======================================

# decode_execute_stage

Single-cycle MIPS decode plus execute slice. It decodes a 32-bit instruction into a 12-bit control word and holds the 32×32 register file. It reads operands, sign-extends the immediate and computes the ALU result with zero and overflow flags. Write-back data arrives from the later memory/write-back logic through `MemtoReg_Data`.

## Interface
- No parameters.
- `Clk`  in  1  register-file write clock, rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all 32 registers.
- `Instruction`  in  32  current instruction.
- `MemtoReg_Data`  in  32  write-back data for the register file.
- `ControlLines`  out  12  decoded control word (bit map below).
- `ReadData1`  out  32  register[rs].
- `ReadData2`  out  32  register[rt].
- `shamt`  out  5  Instruction[10:6].
- `ImmediateField`  out  32  sign-extended Instruction[15:0].
- `ALUresult`  out  32  ALU output.
- `zeroflag`  out  1  ALUresult == 0.
- `overFlow`  out  1  signed overflow of ADD/SUB.

## Operation
- Fields:
  - opcode = [31:26]; rs = [25:21]; rt = [20:16]; rd = [15:11]; shamt = [10:6]; funct = [5:0].
- ControlLines bit map:
  - [11] RegDst; [10] ALUSrc; [9] MemtoReg; [8:5] ALUCtl.
  - [4] RegWrite; [3] MemRead; [2] MemWrite; [1] Branch; [0] Jump.
- ALUCtl codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed).
  - 1100 NOR; 0011 SLL; 0100 SRL; 0101 XOR.
  - Any other code gives result 0.
- Opcode decode, listed as RegDst,ALUSrc,MemtoReg,ALUCtl,RegWrite,MemRead,MemWrite,Branch,Jump:
  - 000000 R-type: 1,0,0,funct-map,1,0,0,0,0.
  - 100011 lw: 0,1,1,0010,1,1,0,0,0.
  - 101011 sw: 0,1,0,0010,0,0,1,0,0.
  - 000100 beq: 0,0,0,0110,0,0,0,1,0.
  - 001000 addi: 0,1,0,0010,1,0,0,0,0.
  - 001100 andi: 0,1,0,0000,1,0,0,0,0.
  - 001101 ori: 0,1,0,0001,1,0,0,0,0.
  - 001010 slti: 0,1,0,0111,1,0,0,0,0.
  - 000010 j: 0,0,0,0000,0,0,0,0,1.
  - Any other opcode: all zeros.
- R-type funct map:
  - 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100110 XOR.
  - 100111 NOR; 101010 SLT; 000000 SLL; 000010 SRL.
  - Any other funct: ALUCtl 0000 with RegWrite 0.
- Immediate is always sign-extended, including for andi and ori.
- ALU operand A = ReadData1.
- ALU operand B = ImmediateField if ALUSrc = 1, else ReadData2.
- Shifts operate on ReadData2 by `shamt` and ignore operand A; SRL is logical.
- overFlow is set only for ADD or SUB when the signed result overflows; it is 0 for every other operation. Results wrap modulo 2^32.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - Reads are combinational.
  - Write address = rd if RegDst = 1, else rt.

## Timing
- Decode, operand read, immediate extension and ALU are purely combinational from `Instruction` and register state; zero cycles of latency.
- Register write occurs on the rising `Clk` edge when RegWrite = 1; the data is `MemtoReg_Data` sampled at that edge.
- No write bypass: a read of the register being written returns the old value until the edge, then the new value.
- While `Reset` = 1, all registers are 0 immediately, independent of `Clk`, and writes are blocked.
- Reset values of outputs: ReadData1 = ReadData2 = 0. The other outputs follow `Instruction` combinationally. ALUresult follows from zero operands, e.g. ImmediateField for ALUSrc = 1 ADD.
- Reset deasserted mid-cycle: the first write happens at the next rising edge.

## Test plan
- Reset, then Instruction = 100011_10001_01000_0000000000011100 (lw $8, 28($17)):
  - ControlLines = 011001011000, ImmediateField = 28, ReadData1 = 0, ALUresult = 28, zeroflag = 0, overFlow = 0.
- Write then reuse:
  - Instruction = addi $17,$0,5 with MemtoReg_Data = 100, one rising edge.
  - Then apply the lw above: ReadData1 = 100, ALUresult = 128.
- Overflow:
  - Load $1 = 0x7FFFFFFF and $2 = 1, then apply add $3,$1,$2.
  - Required: ALUresult = 0x80000000, overFlow = 1.
  - Same operands with sub $3,$1,$1: ALUresult = 0, zeroflag = 1, overFlow = 0.
- Shift, compare and negative immediate:
  - With $2 = 1: sll $4,$0,$2 with shamt 4 gives ALUresult 16.
  - With $1 = −1 and $2 = 1: slt $5,$1,$2 gives ALUresult 1.
  - Immediate 0xFFFF gives ImmediateField 0xFFFFFFFF.
- Register 0 and illegal opcode:
  - Writing $0 with MemtoReg_Data = 55 leaves ReadData for $0 at 0.
  - Opcode 111111 gives ControlLines = 0 and leaves all registers unchanged across a clock edge.
- Asynchronous reset:
  - With $17 = 100, pulse Reset between clock edges; ReadData1 drops to 0 immediately.

Source files
------------

// File: rtl/decode_execute_stage.sv
// Single-cycle MIPS decode + execute slice: control decode, 32x32 register file,
// sign-extended immediate and ALU with zero/overflow flags.
module decode_execute_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] MemtoReg_Data,
  output logic [11:0] ControlLines,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [4:0]  shamt,
  output logic [31:0] ImmediateField,
  output logic [31:0] ALUresult,
  output logic        zeroflag,
  output logic        overFlow
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CTLW  = 4;

  localparam logic [CTLW-1:0] ALU_AND = 4'b0000;
  localparam logic [CTLW-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTLW-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTLW-1:0] ALU_SLL = 4'b0011;
  localparam logic [CTLW-1:0] ALU_SRL = 4'b0100;
  localparam logic [CTLW-1:0] ALU_XOR = 4'b0101;
  localparam logic [CTLW-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTLW-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTLW-1:0] ALU_NOR = 4'b1100;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [AW-1:0]   rs;
  logic [AW-1:0]   rt;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   wr_addr;

  logic            reg_dst;
  logic            alu_src;
  logic            mem_to_reg;
  logic [CTLW-1:0] alu_ctl;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jump;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign shamt  = Instruction[10:6];
  assign funct  = Instruction[5:0];

  // Opcode / funct decode into the control word
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_ctl    = ALU_AND;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    unique case (opcode)
      6'b000000: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b100110: alu_ctl = ALU_XOR;
          6'b100111: alu_ctl = ALU_NOR;
          6'b101010: alu_ctl = ALU_SLT;
          6'b000000: alu_ctl = ALU_SLL;
          6'b000010: alu_ctl = ALU_SRL;
          default: begin
            alu_ctl   = ALU_AND;
            reg_write = 1'b0;
          end
        endcase
      end
      6'b100011: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        alu_ctl    = ALU_ADD;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
      end
      6'b101011: begin
        alu_src   = 1'b1;
        alu_ctl   = ALU_ADD;
        mem_write = 1'b1;
      end
      6'b000100: begin
        alu_ctl = ALU_SUB;
        branch  = 1'b1;
      end
      6'b001000: begin
        alu_src   = 1'b1;
        alu_ctl   = ALU_ADD;
        reg_write = 1'b1;
      end
      6'b001100: begin
        alu_src   = 1'b1;
        alu_ctl   = ALU_AND;
        reg_write = 1'b1;
      end
      6'b001101: begin
        alu_src   = 1'b1;
        alu_ctl   = ALU_OR;
        reg_write = 1'b1;
      end
      6'b001010: begin
        alu_src   = 1'b1;
        alu_ctl   = ALU_SLT;
        reg_write = 1'b1;
      end
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end

  assign ControlLines = {reg_dst, alu_src, mem_to_reg, alu_ctl,
                         reg_write, mem_read, mem_write, branch, jump};

  assign wr_addr = reg_dst ? rd : rt;

  // Next register-file contents: one write per cycle, $0 is never written
  always_comb begin
    regs_d = regs_q;
    if (reg_write && (wr_addr != '0)) begin
      regs_d[wr_addr] = MemtoReg_Data;
    end
  end

  // Register-file state; reset clears everything and blocks writes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ReadData1      = (rs == '0) ? '0 : regs_q[rs];
  assign ReadData2      = (rt == '0) ? '0 : regs_q[rt];
  assign ImmediateField = {{(XLEN-16){Instruction[15]}}, Instruction[15:0]};

  assign op_a = ReadData1;
  assign op_b = alu_src ? ImmediateField : ReadData2;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // ALU result and signed-overflow flag (overflow only meaningful for ADD/SUB)
  always_comb begin
    ALUresult = '0;
    overFlow  = 1'b0;
    case (alu_ctl)
      ALU_AND: ALUresult = op_a & op_b;
      ALU_OR:  ALUresult = op_a | op_b;
      ALU_ADD: begin
        ALUresult = sum;
        overFlow  = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      ALU_SUB: begin
        ALUresult = diff;
        overFlow  = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
      end
      ALU_SLT: ALUresult = XLEN'($signed(op_a) < $signed(op_b));
      ALU_NOR: ALUresult = ~(op_a | op_b);
      ALU_SLL: ALUresult = ReadData2 << shamt;
      ALU_SRL: ALUresult = ReadData2 >> shamt;
      ALU_XOR: ALUresult = op_a ^ op_b;
      default: ALUresult = '0;
    endcase
  end

  assign zeroflag = (ALUresult == '0);

endmodule

// File: tb/tb_decode_execute_stage.sv
// Self-checking bench for decode_execute_stage: directed scenarios plus a
// randomized run against a behavioural register/ALU model.
module tb_decode_execute_stage;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instruction;
  logic [31:0] MemtoReg_Data;
  logic [11:0] ControlLines;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  shamt;
  logic [31:0] ImmediateField;
  logic [31:0] ALUresult;
  logic        zeroflag;
  logic        overFlow;

  int checks = 0;
  int errors = 0;

  bit [31:0] mregs [32];

  localparam logic [31:0] NOP = 32'hFC00_0000;

  decode_execute_stage dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .MemtoReg_Data(MemtoReg_Data),
    .ControlLines(ControlLines), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .shamt(shamt), .ImmediateField(ImmediateField), .ALUresult(ALUresult),
    .zeroflag(zeroflag), .overFlow(overFlow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] r_type(input int s, input int t, input int d, input int sh, input logic [5:0] fn);
    return {6'b000000, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  // Control word straight from the opcode table
  function automatic logic [11:0] model_ctl(input logic [31:0] ins);
    logic [3:0] code;
    logic       ok;
    ok = 1'b1;
    case (ins[5:0])
      6'b100000: code = 4'b0010;
      6'b100010: code = 4'b0110;
      6'b100100: code = 4'b0000;
      6'b100101: code = 4'b0001;
      6'b100110: code = 4'b0101;
      6'b100111: code = 4'b1100;
      6'b101010: code = 4'b0111;
      6'b000000: code = 4'b0011;
      6'b000010: code = 4'b0100;
      default: begin code = 4'b0000; ok = 1'b0; end
    endcase
    case (ins[31:26])
      6'b000000: return {3'b100, code, ok, 4'b0000};
      6'b100011: return 12'b011_0010_11000;
      6'b101011: return 12'b010_0010_00100;
      6'b000100: return 12'b000_0110_00010;
      6'b001000: return 12'b010_0010_10000;
      6'b001100: return 12'b010_0000_10000;
      6'b001101: return 12'b010_0001_10000;
      6'b001010: return 12'b010_0111_10000;
      6'b000010: return 12'b000_0000_00001;
      default:   return 12'b0;
    endcase
  endfunction

  // Behavioural datapath: operands from the model registers, wide signed arithmetic
  task automatic model_eval(input logic [31:0] ins, output logic [11:0] ctl,
                            output logic [31:0] rd1, output logic [31:0] rd2,
                            output logic [31:0] imm, output logic [31:0] res,
                            output logic z, output logic ov);
    longint sa, sb, wide;
    logic [31:0] b;
    ctl  = model_ctl(ins);
    rd1  = mregs[ins[25:21]];
    rd2  = mregs[ins[20:16]];
    imm  = 32'($signed(ins[15:0]));
    b    = ctl[10] ? imm : rd2;
    sa   = longint'($signed(rd1));
    sb   = longint'($signed(b));
    ov   = 1'b0;
    res  = 32'h0;
    case (ctl[8:5])
      4'b0000: res = rd1 & b;
      4'b0001: res = rd1 | b;
      4'b0010: begin wide = sa + sb; res = 32'(wide); ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'b0110: begin wide = sa - sb; res = 32'(wide); ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: res = ~(rd1 | b);
      4'b0011: res = 32'(64'(rd2) * (64'd1 << ins[10:6]));
      4'b0100: res = rd2 / (32'd1 << ins[10:6]);
      4'b0101: res = rd1 ^ b;
      default: res = 32'h0;
    endcase
    z = (res == 32'h0);
  endtask

  // Load a register through an addi-shaped write, keeping the model in step
  task automatic write_reg(input int idx, input logic [31:0] val);
    @(posedge Clk); #1;
    Instruction   = i_type(6'b001000, 0, idx, 16'h0);
    MemtoReg_Data = val;
    @(posedge Clk); #1;
    Instruction = NOP;
    if (idx != 0) mregs[idx] = val;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Instruction   = 32'b100011_10001_01000_0000000000011100;
    MemtoReg_Data = 32'd999;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (ControlLines !== 12'b011001011000) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ControlLines, 12'b011001011000); end
    checks++; if (ImmediateField !== 32'd28) begin errors++; $display("FAIL reset_imm: got %h expected %h", ImmediateField, 32'd28); end
    checks++; if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h/%h expected 0/0", ReadData1, ReadData2); end
    checks++; if (ALUresult !== 32'd28 || zeroflag !== 1'b0 || overFlow !== 1'b0) begin errors++; $display("FAIL reset_alu: got %h z%b v%b expected 1c z0 v0", ALUresult, zeroflag, overFlow); end
    Instruction = NOP;
    @(negedge Clk);
    Reset = 1'b0;
    foreach (mregs[i]) mregs[i] = 32'h0;
  endtask

  task automatic test_write_reuse;
    write_reg(17, 32'd100);
    @(posedge Clk); #1;
    Instruction = 32'b100011_10001_01000_0000000000011100;
    #1;
    checks++; if (ReadData1 !== 32'd100) begin errors++; $display("FAIL reuse_rd1: got %0d expected 100", ReadData1); end
    checks++; if (ALUresult !== 32'd128) begin errors++; $display("FAIL reuse_alu: got %0d expected 128", ALUresult); end
    Instruction = NOP;
  endtask

  task automatic test_overflow;
    write_reg(1, 32'h7FFF_FFFF);
    write_reg(2, 32'd1);
    @(posedge Clk); #1;
    Instruction = r_type(1, 2, 3, 0, 6'b100000);
    #1;
    checks++; if (ALUresult !== 32'h8000_0000 || overFlow !== 1'b1) begin errors++; $display("FAIL add_ovf: got %h v%b expected 80000000 v1", ALUresult, overFlow); end
    Instruction = r_type(1, 1, 3, 0, 6'b100010);
    #1;
    checks++; if (ALUresult !== 32'h0 || zeroflag !== 1'b1 || overFlow !== 1'b0) begin errors++; $display("FAIL sub_zero: got %h z%b v%b expected 0 z1 v0", ALUresult, zeroflag, overFlow); end
    Instruction = NOP;
  endtask

  task automatic test_shift_slt_imm;
    write_reg(1, 32'hFFFF_FFFF);
    @(posedge Clk); #1;
    Instruction = r_type(0, 2, 4, 4, 6'b000000);
    #1;
    checks++; if (ALUresult !== 32'd16) begin errors++; $display("FAIL sll: got %0d expected 16", ALUresult); end
    Instruction = r_type(1, 2, 5, 0, 6'b101010);
    #1;
    checks++; if (ALUresult !== 32'd1) begin errors++; $display("FAIL slt: got %0d expected 1", ALUresult); end
    Instruction = i_type(6'b001000, 0, 6, 16'hFFFF);
    #1;
    checks++; if (ImmediateField !== 32'hFFFF_FFFF) begin errors++; $display("FAIL imm_neg: got %h expected ffffffff", ImmediateField); end
    Instruction = NOP;
  endtask

  task automatic test_reg0_illegal;
    logic [11:0] c; logic [31:0] r1, r2, im, rs; logic z, v;
    write_reg(0, 32'd55);
    @(posedge Clk); #1;
    Instruction = r_type(0, 0, 0, 0, 6'b100101);
    #1;
    checks++; if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin errors++; $display("FAIL reg0: got %h/%h expected 0/0", ReadData1, ReadData2); end
    Instruction   = {6'b111111, 26'($urandom)};
    MemtoReg_Data = $urandom;
    #1;
    checks++; if (ControlLines !== 12'h0) begin errors++; $display("FAIL illegal_ctl: got %b expected 0", ControlLines); end
    @(posedge Clk); #1;
    for (int i = 0; i < 32; i++) begin
      Instruction = i_type(6'b111111, i, 31 - i, 16'h0);
      #1;
      model_eval(Instruction, c, r1, r2, im, rs, z, v);
      checks++; if (ReadData1 !== r1 || ReadData2 !== r2) begin errors++; $display("FAIL illegal_regs[%0d]: got %h/%h expected %h/%h", i, ReadData1, ReadData2, r1, r2); end
    end
    Instruction = NOP;
  endtask

  task automatic test_async_reset;
    write_reg(17, 32'd100);
    @(negedge Clk);
    Instruction   = 32'b100011_10001_01000_0000000000011100;
    MemtoReg_Data = 32'hABCD_0001;
    #1;
    checks++; if (ReadData1 !== 32'd100) begin errors++; $display("FAIL areset_pre: got %0d expected 100", ReadData1); end
    Reset = 1'b1;
    #1;
    checks++; if (ReadData1 !== 32'd0 || ALUresult !== 32'd28) begin errors++; $display("FAIL areset_drop: got %0d alu %0d expected 0 alu 28", ReadData1, ALUresult); end
    foreach (mregs[i]) mregs[i] = 32'h0;
    @(posedge Clk); #1;
    Instruction = i_type(6'b111111, 8, 0, 16'h0);
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("FAIL areset_block: got %h expected 0", ReadData1); end
    Instruction = 32'b100011_10001_01000_0000000000011100;
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
    mregs[8] = 32'hABCD_0001;
    Instruction = i_type(6'b111111, 8, 0, 16'h0);
    #1;
    checks++; if (ReadData1 !== 32'hABCD_0001) begin errors++; $display("FAIL areset_first_write: got %h expected abcd0001", ReadData1); end
    Instruction = NOP;
  endtask

  task automatic test_random;
    logic [5:0] ops [10] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                             6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    logic [5:0] fns [9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                             6'b100111, 6'b101010, 6'b000000, 6'b000010};
    logic [11:0] c; logic [31:0] r1, r2, im, rs, ins; logic z, v;
    for (int i = 1; i < 32; i++) write_reg(i, (i % 4 == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom);
    for (int n = 0; n < 400; n++) begin
      @(posedge Clk); #1;
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[31:26] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) != 0) ins[5:0]   = fns[$urandom_range(0, 8)];
      Instruction   = ins;
      MemtoReg_Data = $urandom;
      #1;
      model_eval(ins, c, r1, r2, im, rs, z, v);
      checks++; if (ControlLines !== c) begin errors++; $display("FAIL rnd_ctl %h: got %b expected %b", ins, ControlLines, c); end
      checks++; if (ReadData1 !== r1 || ReadData2 !== r2) begin errors++; $display("FAIL rnd_rd %h: got %h/%h expected %h/%h", ins, ReadData1, ReadData2, r1, r2); end
      checks++; if (ImmediateField !== im || shamt !== ins[10:6]) begin errors++; $display("FAIL rnd_imm %h: got %h/%0d expected %h/%0d", ins, ImmediateField, shamt, im, ins[10:6]); end
      checks++; if (ALUresult !== rs || zeroflag !== z || overFlow !== v) begin errors++; $display("FAIL rnd_alu %h: got %h z%b v%b expected %h z%b v%b", ins, ALUresult, zeroflag, overFlow, rs, z, v); end
      @(posedge Clk);
      if (c[4]) begin
        if (c[11] && ins[15:11] != 5'd0) mregs[ins[15:11]] = MemtoReg_Data;
        if (!c[11] && ins[20:16] != 5'd0) mregs[ins[20:16]] = MemtoReg_Data;
      end
      #1 Instruction = NOP;
    end
  endtask

  initial begin
    Reset = 1'b1;
    Instruction = NOP;
    MemtoReg_Data = 32'h0;
    test_reset();
    test_write_reuse();
    test_overflow();
    test_shift_slt_imm();
    test_reg0_illegal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
